// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - writeback requester, write-port and scoreboard signal bundle
interface rf_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*5-1:0]    req_rd;
  logic [NUM_REQ*XLEN-1:0] req_data;
  logic                    rf_we;
  logic [4:0]              rf_rd;
  logic [XLEN-1:0]         rf_rd_data;
  logic                    issue_valid;
  logic [4:0]              issue_rd;
  logic                    issue_ready;
  logic [4:0]              rs1;
  logic [4:0]              rs2;
  logic                    rs1_busy;
  logic                    rs2_busy;

  modport master (
    output req_valid, req_rd, req_data, issue_valid, issue_rd, rs1, rs2,
    input  req_ready, rf_we, rf_rd, rf_rd_data, issue_ready, rs1_busy, rs2_busy
  );

  modport slave (
    input  req_valid, req_rd, req_data, issue_valid, issue_rd, rs1, rs2,
    output req_ready, rf_we, rf_rd, rf_rd_data, issue_ready, rs1_busy, rs2_busy
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin register-file write-port arbiter with pending-write scoreboard
module rf_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32,
  parameter int CNT_W   = 2
) (
  input logic           clk,
  input logic           reset,
  rf_wb_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PTR_W-1:0]   ptr;
  logic               grant_any;
  logic [PTR_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic [4:0]         sel_rd;
  logic [XLEN-1:0]    sel_data;
  logic               xfer;

  logic               we_q;
  logic [4:0]         rd_q;
  logic [XLEN-1:0]    data_q;

  logic [CNT_W-1:0]   cnt [32];
  logic               issue_sat;
  logic               issue_fire;

  // Round-robin winner: first valid above the last winner, then wrap to the lowest index.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && (PTR_W'(i) > ptr) && bus.req_valid[i]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && (PTR_W'(i) <= ptr) && bus.req_valid[i]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(i);
      end
    end
  end

  // One-hot grant and the winner's destination/data steered toward the write port.
  always_comb begin
    grant    = '0;
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_any && (grant_idx == PTR_W'(i))) begin
        grant[i] = 1'b1;
        sel_rd   = bus.req_rd[5*i +: 5];
        sel_data = bus.req_data[XLEN*i +: XLEN];
      end
    end
  end

  assign xfer          = grant_any && !reset;
  assign bus.req_ready = reset ? '0 : grant;

  // Registered write port; a write to x0 is swallowed here so reg_file never sees it.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
      ptr    <= PTR_W'(NUM_REQ - 1);
    end else begin
      we_q <= xfer && (sel_rd != 5'd0);
      if (xfer) begin
        rd_q   <= sel_rd;
        data_q <= sel_data;
        ptr    <= grant_idx;
      end
    end
  end

  assign bus.rf_we      = we_q;
  assign bus.rf_rd      = rd_q;
  assign bus.rf_rd_data = data_q;

  // A full counter can still take an issue when the same register retires in this cycle.
  assign issue_sat       = (cnt[bus.issue_rd] == CNT_MAX) && !(we_q && (rd_q == bus.issue_rd));
  assign bus.issue_ready = !reset && !issue_sat;
  assign issue_fire      = bus.issue_valid && bus.issue_ready && (bus.issue_rd != 5'd0);

  // Pending-write counters: issue increments, commit decrements, both together cancel.
  always_ff @(posedge clk) begin
    cnt[0] <= '0;
    for (int r = 1; r < 32; r++) begin
      if (reset) begin
        cnt[r] <= '0;
      end else if (issue_fire && (bus.issue_rd == 5'(r)) && !(we_q && (rd_q == 5'(r)))) begin
        cnt[r] <= cnt[r] + CNT_W'(1);
      end else if (we_q && (rd_q == 5'(r)) && !(issue_fire && (bus.issue_rd == 5'(r)))
                   && (cnt[r] != '0)) begin
        cnt[r] <= cnt[r] - CNT_W'(1);
      end
    end
  end

  assign bus.rs1_busy = (bus.rs1 != 5'd0) && (cnt[bus.rs1] != '0);
  assign bus.rs2_busy = (bus.rs2 != 5'd0) && (cnt[bus.rs2] != '0);

  // Every committed write must retire a write that decode previously issued.
  always @(posedge clk) begin
    if (!reset && we_q) begin
      assert (cnt[rd_q] != '0);
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter with a behavioural model
module tb_rf_wb_arbiter;
  localparam int NR = 3;
  localparam int XL = 32;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  rf_wb_arbiter_if #(.NUM_REQ(NR), .XLEN(XL)) bus ();

  rf_wb_arbiter #(.NUM_REQ(NR), .XLEN(XL), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model: last winner, outstanding writes per register, expected write port.
  int          m_ptr;
  int          m_cnt [32];
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  int          owed [32];

  function automatic int exp_grant();
    if (reset) return -1;
    for (int k = 1; k <= NR; k++) begin
      if (bus.req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] exp_ready();
    int g;
    g = exp_grant();
    return (g < 0) ? '0 : (NR'(1) << g);
  endfunction

  function automatic bit exp_issue_ready();
    if (reset) return 1'b0;
    if (bus.issue_rd != 0 && m_cnt[bus.issue_rd] == 3 && !(m_we && m_rd == bus.issue_rd)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_busy(input logic [4:0] r);
    return (r != 0) && (m_cnt[r] != 0);
  endfunction

  task automatic tick();
    int          g;
    bit          fire;
    logic [4:0]  ird;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    g     = exp_grant();
    fire  = bus.issue_valid && exp_issue_ready() && (bus.issue_rd != 0);
    ird   = bus.issue_rd;
    wrd   = (g >= 0) ? bus.req_rd[5*g +: 5] : 5'd0;
    wdata = (g >= 0) ? bus.req_data[XL*g +: XL] : 32'd0;
    @(posedge clk);
    if (reset) begin
      m_we = 0; m_rd = 0; m_data = 0; m_ptr = NR - 1;
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    end else begin
      if (m_we && m_cnt[m_rd] > 0) m_cnt[m_rd]--;
      if (fire) m_cnt[ird]++;
      if (g >= 0) begin
        m_we = (wrd != 0); m_rd = wrd; m_data = wdata; m_ptr = g;
      end else begin
        m_we = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input bit v, input logic [4:0] rd, input logic [31:0] d);
    bus.req_valid[i]         = v;
    bus.req_rd[5*i +: 5]     = rd;
    bus.req_data[XL*i +: XL] = d;
  endtask

  task automatic clear_inputs();
    bus.req_valid   = '0;
    bus.req_rd      = '0;
    bus.req_data    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.rs1         = '0;
    bus.rs2         = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
    for (int r = 0; r < 32; r++) owed[r] = 0;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = rd;
    #1;
    checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL issue_ready_x%0d: got %b want 1", rd, bus.issue_ready); end
    tick();
    bus.issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 5'd0, 32'hA5A5_0000 + i);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd3;
    tick();
    #1;
    checks++; if (bus.req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b want 000", bus.req_ready); end
    checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL reset_issue_ready: got %b want 0", bus.issue_ready); end
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b want 0", bus.rf_we); end
    checks++; if (bus.rf_rd !== 5'd0) begin errors++; $display("FAIL reset_rf_rd: got %0d want 0", bus.rf_rd); end
    checks++; if (bus.rf_rd_data !== 32'd0) begin errors++; $display("FAIL reset_rf_rd_data: got %h want 0", bus.rf_rd_data); end
    reset = 1'b0;
    clear_inputs();
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      bus.rs1 = 5'($urandom_range(0, 31));
      bus.rs2 = 5'($urandom_range(0, 31));
      #1;
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL idle_rf_we: got %b want 0", bus.rf_we); end
      checks++; if ({bus.rs1_busy, bus.rs2_busy} !== 2'b00) begin errors++; $display("FAIL idle_busy: got %b want 00", {bus.rs1_busy, bus.rs2_busy}); end
      tick();
    end
  endtask

  task automatic test_single();
    do_reset();
    issue(5'd5);
    set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    bus.rs1 = 5'd5;
    #1;
    checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL single_ready: got %b want 010", bus.req_ready); end
    tick();
    set_req(1, 1'b0, 5'd0, 32'd0);
    #1;
    checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("FAIL single_rf_we: got %b want 1", bus.rf_we); end
    checks++; if (bus.rf_rd !== 5'd5) begin errors++; $display("FAIL single_rf_rd: got %0d want 5", bus.rf_rd); end
    checks++; if (bus.rf_rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rf_rd_data: got %h want deadbeef", bus.rf_rd_data); end
    checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL single_busy_n1: got %b want 1", bus.rs1_busy); end
    tick();
    #1;
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL single_rf_we_after: got %b want 0", bus.rf_we); end
    checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL single_busy_n2: got %b want 0", bus.rs1_busy); end
  endtask

  task automatic test_contention();
    logic [31:0] d [NR];
    do_reset();
    for (int r = 1; r <= 3; r++) begin
      issue(5'(r));
      issue(5'(r));
    end
    for (int i = 0; i < NR; i++) begin
      d[i] = $urandom;
      set_req(i, 1'b1, 5'(i + 1), d[i]);
    end
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++; if (bus.req_ready !== (3'b001 << (c % 3))) begin errors++; $display("FAIL contention_grant_%0d: got %b want %b", c, bus.req_ready, 3'b001 << (c % 3)); end
      tick();
      if (c == 5) bus.req_valid = '0;
      #1;
      checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'(c % 3 + 1) || bus.rf_rd_data !== d[c % 3]) begin
        errors++; $display("FAIL contention_write_%0d: got we=%b rd=%0d data=%h want we=1 rd=%0d data=%h", c, bus.rf_we, bus.rf_rd, bus.rf_rd_data, c % 3 + 1, d[c % 3]);
      end
    end
    bus.rs1 = 5'd1;
    bus.rs2 = 5'd3;
    tick();
    #1;
    checks++; if ({bus.rf_we, bus.rs1_busy, bus.rs2_busy} !== 3'b000) begin errors++; $display("FAIL contention_drained: got we/busy1/busy2=%b want 000", {bus.rf_we, bus.rs1_busy, bus.rs2_busy}); end
  endtask

  task automatic test_raw();
    do_reset();
    issue(5'd7);
    bus.rs1 = 5'd7;
    bus.rs2 = 5'd0;
    #1;
    checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL raw_busy_after_issue: got %b want 1", bus.rs1_busy); end
    checks++; if (bus.rs2_busy !== 1'b0) begin errors++; $display("FAIL raw_x0_busy: got %b want 0", bus.rs2_busy); end
    set_req(2, 1'b1, 5'd7, 32'h1234_5678);
    #1;
    checks++; if (bus.req_ready !== 3'b100) begin errors++; $display("FAIL raw_ready: got %b want 100", bus.req_ready); end
    tick();
    set_req(2, 1'b0, 5'd0, 32'd0);
    #1;
    checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL raw_busy_n1: got %b want 1", bus.rs1_busy); end
    tick();
    #1;
    checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL raw_busy_n2: got %b want 0", bus.rs1_busy); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 3; k++) issue(5'd9);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd9;
    bus.rs1         = 5'd9;
    set_req(0, 1'b1, 5'd9, 32'h0000_0909);
    #1;
    checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL sat_issue_ready: got %b want 0", bus.issue_ready); end
    checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL sat_busy: got %b want 1", bus.rs1_busy); end
    tick();
    set_req(0, 1'b0, 5'd0, 32'd0);
    #1;
    checks++; if (bus.rf_we !== 1'b1 || bus.issue_ready !== 1'b1) begin errors++; $display("FAIL sat_simul: got we=%b issue_ready=%b want 1 1", bus.rf_we, bus.issue_ready); end
    tick();
    #1;
    checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL sat_still_full: got %b want 0", bus.issue_ready); end
    bus.issue_valid = 1'b0;
  endtask

  task automatic test_rd0();
    do_reset();
    set_req(1, 1'b1, 5'd0, 32'hFFFF_0000);
    #1;
    checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL rd0_ready: got %b want 010", bus.req_ready); end
    tick();
    set_req(1, 1'b0, 5'd0, 32'd0);
    set_req(0, 1'b1, 5'd0, 32'd1);
    set_req(2, 1'b1, 5'd0, 32'd2);
    #1;
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL rd0_rf_we: got %b want 0", bus.rf_we); end
    checks++; if (bus.req_ready !== 3'b100) begin errors++; $display("FAIL rd0_next_grant: got %b want 100", bus.req_ready); end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue(5'd4);
    issue(5'd4);
    set_req(1, 1'b1, 5'd0, 32'd0);
    tick();
    bus.req_valid = '0;
    set_req(0, 1'b1, 5'd4, 32'h4444_4444);
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL mid_ready: got %b want 001", bus.req_ready); end
    tick();
    reset = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 5'd0, 32'd0);
    #1;
    checks++; if (bus.req_ready !== '0) begin errors++; $display("FAIL mid_ready_in_reset: got %b want 000", bus.req_ready); end
    tick();
    reset = 1'b0;
    bus.rs1 = 5'd4;
    #1;
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL mid_rf_we: got %b want 0", bus.rf_we); end
    checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", bus.rs1_busy); end
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL mid_ptr_restart: got %b want 001", bus.req_ready); end
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    bit          active [NR];
    int          cand [$];
    int          g;
    bit          fire;
    logic [4:0]  ird;
    logic [4:0]  rd;
    do_reset();
    for (int i = 0; i < NR; i++) active[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NR; i++) begin
        if (!active[i] && $urandom_range(0, 1) == 1) begin
          cand.delete();
          for (int r = 1; r < 8; r++) if (owed[r] > 0) cand.push_back(r);
          rd = 5'd0;
          if (cand.size() > 0 && $urandom_range(0, 3) != 0) begin
            rd = 5'(cand[$urandom_range(0, cand.size() - 1)]);
            owed[rd]--;
          end
          set_req(i, 1'b1, rd, $urandom);
          active[i] = 1;
        end
      end
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_rd    = 5'($urandom_range(0, 7));
      bus.rs1         = 5'($urandom_range(0, 7));
      bus.rs2         = 5'($urandom_range(0, 7));
      #1;
      checks++; if (bus.req_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, bus.req_ready, exp_ready()); end
      checks++; if (bus.issue_ready !== exp_issue_ready()) begin errors++; $display("FAIL rand_issue_ready@%0d: got %b want %b", cyc, bus.issue_ready, exp_issue_ready()); end
      checks++; if (bus.rs1_busy !== exp_busy(bus.rs1) || bus.rs2_busy !== exp_busy(bus.rs2)) begin
        errors++; $display("FAIL rand_busy@%0d: got %b%b want %b%b", cyc, bus.rs1_busy, bus.rs2_busy, exp_busy(bus.rs1), exp_busy(bus.rs2));
      end
      checks++; if (bus.rf_we !== m_we) begin errors++; $display("FAIL rand_rf_we@%0d: got %b want %b", cyc, bus.rf_we, m_we); end
      if (m_we) begin
        checks++; if (bus.rf_rd !== m_rd || bus.rf_rd_data !== m_data) begin
          errors++; $display("FAIL rand_rf_write@%0d: got rd=%0d data=%h want rd=%0d data=%h", cyc, bus.rf_rd, bus.rf_rd_data, m_rd, m_data);
        end
      end
      g    = exp_grant();
      fire = bus.issue_valid && exp_issue_ready() && (bus.issue_rd != 0);
      ird  = bus.issue_rd;
      tick();
      if (fire) owed[ird]++;
      if (g >= 0) begin
        active[g] = 0;
        bus.req_valid[g] = 1'b0;
      end
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_contention();
    test_raw();
    test_saturation();
    test_rd0();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the single register-file write port among NUM_REQ writeback requesters, such as the ALU, the load unit and the multiply/divide unit, using round-robin arbitration with a valid/ready handshake. It also holds a per-register scoreboard of in-flight writes, so decode can detect RAW hazards against registers not yet written. It sits between the writeback sources and reg_file. Its registered write-port outputs drive the reg_file we/rd/rd_data inputs.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
XLEN, 32, data width
CNT_W, 2, width of per-register pending counter; max outstanding writes per register = 2^CNT_W-1

Ports:
clk  input  1  clock
reset  input  1  reset
req_valid  input  NUM_REQ  per-requester write request
req_ready  output  NUM_REQ  per-requester grant/accept (combinational)
req_rd  input  NUM_REQ*5  destination register per requester, requester i at bits [5i+4:5i]
req_data  input  NUM_REQ*XLEN  write data per requester, requester i at bits [XLEN*i+XLEN-1:XLEN*i]
rf_we  output  1  register-file write enable (registered)
rf_rd  output  5  register-file write address (registered)
rf_rd_data  output  XLEN  register-file write data (registered)
issue_valid  input  1  decode issues an instruction that will write issue_rd
issue_rd  input  5  destination of issuing instruction
issue_ready  output  1  scoreboard can accept issue_rd (combinational)
rs1  input  5  decode source 1 query
rs2  input  5  decode source 2 query
rs1_busy  output  1  rs1 has a pending write (combinational)
rs2_busy  output  1  rs2 has a pending write (combinational)

Behaviour:
- Reset (reset is synchronous, active-high; clock is clk):
  - on the reset edge: rf_we=0, rf_rd=0, rf_rd_data=0, all pending counters=0, RR pointer=NUM_REQ-1 (requester 0 wins first).
  - while reset=1: req_ready=0 and issue_ready=0.
  - reset mid-stream drops any registered write and clears the scoreboard; requesters must re-present.
- Arbitration:
  - each cycle, grant at most one valid requester, searching upward from pointer+1 modulo NUM_REQ.
  - req_ready[i]=1 only for the granted i; a transfer occurs when valid&ready.
  - the pointer updates to i on a transfer and holds when there is no transfer.
  - requesters hold valid/rd/data stable until accepted; valid must not drop before acceptance.
  - with a single continuous requester, it is granted every cycle (full throughput, no bubbles).
- Write-port pipeline:
  - a transfer in cycle N produces rf_we=1, rf_rd=req_rd[i], rf_rd_data=req_data[i] in cycle N+1; reg_file commits at the end of N+1.
  - no transfer gives rf_we=0 the next cycle; rf_rd and rf_rd_data hold their last values.
  - a transfer with rd=0 is accepted normally but produces rf_we=0 and does not touch the scoreboard.
- Scoreboard:
  - one CNT_W-bit counter per register 1..31; register 0 is never busy.
  - increment on issue_valid&issue_ready with issue_rd!=0.
  - decrement on the edge where registered rf_we=1 commits rf_rd.
  - simultaneous increment and decrement of the same register leaves the counter unchanged.
  - issue_ready=0 when counter[issue_rd] is saturated and no decrement of issue_rd occurs this cycle; otherwise 1 (including issue_rd=0).
  - rsX_busy = (rsX!=0) && counter[rsX]!=0. A write committing in cycle N+1 clears busy in N+2, when reg_file reads the new value.
  - a decrement of a zero counter is a protocol error: the counter stays 0 and a simulation assertion fires.
- All outputs are single-driver; there is no combinational path from req_* to rf_*.

Test Plan:
- Reset then idle: all rf_* outputs 0, req_ready=0 during reset; after release with no valid, rf_we stays 0 and rs1_busy=rs2_busy=0 for any rs.
- Single requester: req1 valid with rd=5, data=0xDEADBEEF at cycle N -> req_ready=3'b010 at N; at N+1 rf_we=1, rf_rd=5, rf_rd_data=0xDEADBEEF.
- Contention: all 3 requesters valid continuously with rd=1,2,3 -> grants in order 0,1,2,0,1,2 on consecutive cycles, one rf_we per cycle, no starvation.
- Scoreboard RAW:
  - issue rd=7 -> rs1=7 gives rs1_busy=1 next cycle.
  - a requester writes x7 accepted at N -> busy is still 1 in N+1 and becomes 0 in N+2.
  - rs1=0 always gives busy=0.
- Saturation and simultaneous events:
  - 3 issues to rd=9 leave the counter at 3 and issue_ready=0 for rd=9.
  - issuing rd=9 in the same cycle a write to x9 commits leaves the counter at 3 and issue_ready=1.
- rd=0 and mid-reset:
  - write to rd=0 is accepted with rf_we=0.
  - reset asserted while x4 is pending and a grant is in flight -> next cycle rf_we=0, rs1=4 not busy, and the pointer restarts at requester 0.
